// File: rtl/mem_copy_pkg.sv
// -----------------------------------------------------------------------------
// mem_copy_pkg
// Shared types and helpers for the mem_copy_master block-copy engine.
//   state_e  : copy FSM states (IDLE, RD, WR, FIN)
//   dir_e    : cursor direction (ASC, DESC)
//   copy_dir : picks the copy order that keeps overlapping copies intact
// -----------------------------------------------------------------------------
package mem_copy_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } state_e;

    typedef enum logic {
        ASC  = 1'b0,
        DESC = 1'b1
    } dir_e;

    // The destination start lies inside the not-yet-read part of the source
    // window when (dst - src) mod 2**depth < len; copying from the top end
    // down then reads every source word before it can be overwritten.
    function automatic dir_e copy_dir(input logic [31:0] src,
                                      input logic [31:0] dst,
                                      input logic [31:0] len,
                                      input int unsigned depth);
        logic [31:0] mask;
        logic [31:0] diff;
        mask = (32'd1 << depth) - 32'd1;
        diff = (dst - src) & mask;
        if ((dst != src) && (diff < len)) begin
            return DESC;
        end
        return ASC;
    endfunction

endpackage

// File: rtl/mem_copy_master_if.sv
// -----------------------------------------------------------------------------
// mem_copy_master_if
// Single-port synchronous RAM port as seen by a copy initiator.
//   read      : read strobe, dataRead valid the following cycle
//   write     : write strobe, memory updated at the closing clock edge
//   addr      : word address (zero-extended)
//   dataWrite : write data
//   dataRead  : registered RAM output
// Modports: master (initiator side), slave (RAM side).
// -----------------------------------------------------------------------------
interface mem_copy_master_if;

    logic               read;
    logic               write;
    logic signed [31:0] addr;
    logic signed [31:0] dataWrite;
    logic signed [31:0] dataRead;

    modport master (
        output read,
        output write,
        output addr,
        output dataWrite,
        input  dataRead
    );

    modport slave (
        input  read,
        input  write,
        input  addr,
        input  dataWrite,
        output dataRead
    );

endinterface

// File: rtl/mem_copy_addr_gen.sv
// -----------------------------------------------------------------------------
// mem_copy_addr_gen
// Source/destination cursors and remaining-word count for mem_copy_master.
//   clk, reset : clock, asynchronous active-low reset
//   load       : latch src/dst/len and choose direction
//   step       : advance both cursors one word, decrement count
//   src, dst   : first source / destination word address of the command
//   len        : word count (0 .. 2**data_depth)
//   src_cur    : current source cursor
//   dst_cur    : current destination cursor
//   last       : the word at the cursors is the final one of the command
// -----------------------------------------------------------------------------
module mem_copy_addr_gen
    import mem_copy_pkg::*;
#(
    parameter int data_depth = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  step,
    input  logic [data_depth-1:0] src,
    input  logic [data_depth-1:0] dst,
    input  logic [data_depth:0]   len,
    output logic [data_depth-1:0] src_cur,
    output logic [data_depth-1:0] dst_cur,
    output logic                  last
);

    localparam logic [data_depth-1:0] ONE     = data_depth'(1);
    localparam logic [data_depth:0]   CNT_ONE = (data_depth+1)'(1);

    dir_e                  dir_q, dir_d;
    logic [data_depth-1:0] src_q, src_d;
    logic [data_depth-1:0] dst_q, dst_d;
    logic [data_depth:0]   cnt_q, cnt_d;
    logic [data_depth-1:0] span_m1;

    always_comb begin
        // len-1 taken modulo the RAM size; for a full-RAM copy this wraps
        // to all ones, which puts the descending start just below src.
        span_m1 = len[data_depth-1:0] - ONE;
        dir_d   = dir_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        if (load) begin
            dir_d = copy_dir(32'(src), 32'(dst), 32'(len), data_depth);
            cnt_d = len;
            if (dir_d == DESC) begin
                src_d = src + span_m1;
                dst_d = dst + span_m1;
            end else begin
                src_d = src;
                dst_d = dst;
            end
        end else if (step) begin
            cnt_d = cnt_q - CNT_ONE;
            if (dir_q == DESC) begin
                src_d = src_q - ONE;
                dst_d = dst_q - ONE;
            end else begin
                src_d = src_q + ONE;
                dst_d = dst_q + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dir_q <= ASC;
            src_q <= '0;
            dst_q <= '0;
            cnt_q <= '0;
        end else begin
            dir_q <= dir_d;
            src_q <= src_d;
            dst_q <= dst_d;
            cnt_q <= cnt_d;
        end
    end

    assign src_cur = src_q;
    assign dst_cur = dst_q;
    assign last    = (cnt_q == CNT_ONE);

endmodule

// File: rtl/mem_copy_master.sv
// -----------------------------------------------------------------------------
// mem_copy_master
// Overlap-safe block-copy initiator for a single-port synchronous RAM.
// Each word takes one RD cycle and one WR cycle; the write data is the RAM
// output register passed straight through during WR.
//   clk, reset : clock, asynchronous active-low reset
//   start      : command strobe, honoured only in IDLE
//   src, dst   : first source / destination word address
//   len        : word count (0 .. 2**data_depth)
//   busy       : copy in progress (cycle after start through last write)
//   done       : one-cycle completion pulse
//   ram        : RAM port (master modport)
// -----------------------------------------------------------------------------
module mem_copy_master
    import mem_copy_pkg::*;
#(
    parameter int data_depth = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [data_depth-1:0]    src,
    input  logic [data_depth-1:0]    dst,
    input  logic [data_depth:0]      len,
    output logic                     busy,
    output logic                     done,
    mem_copy_master_if.master        ram
);

    state_e                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  read_q, read_d;
    logic                  write_q, write_d;
    logic                  load;
    logic                  step;
    logic [data_depth-1:0] src_cur;
    logic [data_depth-1:0] dst_cur;
    logic                  last;
    logic [data_depth-1:0] addr_sel;

    mem_copy_addr_gen #(
        .data_depth (data_depth)
    ) u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .step    (step),
        .src     (src),
        .dst     (dst),
        .len     (len),
        .src_cur (src_cur),
        .dst_cur (dst_cur),
        .last    (last)
    );

    // Strobes and status are computed for the next state so that they come
    // straight out of flops alongside the state register.
    always_comb begin
        state_d = state_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        read_d  = 1'b0;
        write_d = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load = 1'b1;
                    if (len != '0) begin
                        state_d = RD;
                        busy_d  = 1'b1;
                        read_d  = 1'b1;
                    end else begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end
                end
            end
            RD: begin
                state_d = WR;
                busy_d  = 1'b1;
                write_d = 1'b1;
            end
            WR: begin
                step = 1'b1;
                if (!last) begin
                    state_d = RD;
                    busy_d  = 1'b1;
                    read_d  = 1'b1;
                end else begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            read_q  <= read_d;
            write_q <= write_d;
        end
    end

    always_comb begin
        addr_sel = '0;
        if (read_q) begin
            addr_sel = src_cur;
        end else if (write_q) begin
            addr_sel = dst_cur;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign ram.read      = read_q;
    assign ram.write     = write_q;
    assign ram.addr      = {{(32-data_depth){1'b0}}, addr_sel};
    assign ram.dataWrite = write_q ? ram.dataRead : 32'sd0;

endmodule

// File: tb/tb_mem_copy_master.sv
module tb_mem_copy_master;

    localparam int DD = 4;
    localparam int N  = 1 << DD;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [DD-1:0] src   = '0;
    logic [DD-1:0] dst   = '0;
    logic [DD:0]   len   = '0;
    logic          busy;
    logic          done;

    mem_copy_master_if bus();

    mem_copy_master #(.data_depth(DD)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .src   (src),
        .dst   (dst),
        .len   (len),
        .busy  (busy),
        .done  (done),
        .ram   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous single-port RAM model; init_req bulk-loads init_img.
    logic signed [31:0] ram_mem  [N];
    logic signed [31:0] init_img [N];
    logic signed [31:0] model_mem[N];
    logic signed [31:0] old_mem  [N];
    logic               init_req = 1'b0;

    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < N; i++) ram_mem[i] <= init_img[i];
        end else if (bus.write) begin
            ram_mem[bus.addr[DD-1:0]] <= bus.dataWrite;
        end
        if (bus.read) bus.dataRead <= ram_mem[bus.addr[DD-1:0]];
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard: kind 0 = read, 1 = write, 2 = done
    typedef struct {
        int kind;
        int cyc;
        int addr;
        int data;
    } ev_t;
    ev_t exp_q[$];

    task automatic push(input int k, input int c, input int a, input int d);
        ev_t e;
        e.kind = k; e.cyc = c; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        ev_t e;
        int  kind;
        if (reset === 1'b1) begin
            if (bus.read && bus.write) chk(1'b0, "rd_wr_same_cycle", 1, 0);
            if (bus.read || bus.write || done) begin
                kind = done ? 2 : (bus.write ? 1 : 0);
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_event", kind, -1);
                end else begin
                    e = exp_q.pop_front();
                    chk(kind == e.kind, "event_kind", kind, e.kind);
                    chk(cyc == e.cyc, "event_cycle", cyc, e.cyc);
                    chk(busy == (e.kind != 2), "busy", busy, (e.kind != 2));
                    if (e.kind != 2) chk(int'(bus.addr) == e.addr, "addr", bus.addr, e.addr);
                    if (e.kind == 1) chk(int'(bus.dataWrite) == e.data, "write_data", bus.dataWrite, e.data);
                end
            end
        end
    end

    // Reference: a copy is a sequence of word moves in the chosen order
    // applied to the model memory; nwords < l models an aborted copy.
    task automatic model_cmd(input int c, input int s, input int d, input int l, input int nwords);
        bit desc;
        int rs;
        int ws;
        desc = (s != d) && (((d - s) & (N - 1)) < l);
        rs   = desc ? ((s + l - 1) & (N - 1)) : s;
        ws   = desc ? ((d + l - 1) & (N - 1)) : d;
        for (int k = 0; k < nwords; k++) begin
            push(0, c + 1 + 2 * k, rs, 0);
            push(1, c + 2 + 2 * k, ws, model_mem[rs]);
            model_mem[ws] = model_mem[rs];
            rs = desc ? ((rs - 1) & (N - 1)) : ((rs + 1) & (N - 1));
            ws = desc ? ((ws - 1) & (N - 1)) : ((ws + 1) & (N - 1));
        end
        if (nwords == l) push(2, c + 1 + 2 * l, 0, 0);
    endtask

    function automatic int mem_diffs();
        int n;
        n = 0;
        for (int i = 0; i < N; i++) if (ram_mem[i] !== model_mem[i]) n++;
        return n;
    endfunction

    task automatic check_idle(input string name);
        chk({busy, done, bus.read, bus.write} == 4'b0000, {name, "_ctrl"},
            {busy, done, bus.read, bus.write}, 0);
        chk(bus.addr == 32'sd0 && bus.dataWrite == 32'sd0, {name, "_bus"},
            bus.addr | bus.dataWrite, 0);
    endtask

    // mode 0: i+100, mode 1: i, otherwise random
    task automatic load_ram(input int mode);
        for (int i = 0; i < N; i++) begin
            if (mode == 0)      init_img[i] = 32'(i + 100);
            else if (mode == 1) init_img[i] = 32'(i);
            else                init_img[i] = $urandom;
            model_mem[i] = init_img[i];
        end
        @(negedge clk);
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
    endtask

    task automatic run_cmd(input int s, input int d, input int l, input bit hold);
        int c;
        @(negedge clk);
        c     = cyc;
        src   = DD'(s);
        dst   = DD'(d);
        len   = (DD+1)'(l);
        start = 1'b1;
        model_cmd(c, s, d, l, l);
        @(negedge clk);
        while (cyc < c + 2 * l + 2) begin
            if (hold) begin
                start = 1'b1;
                src   = DD'($urandom);
                dst   = DD'($urandom);
                len   = (DD+1)'($urandom_range(1, N));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk(exp_q.size() == 0, "missing_events", exp_q.size(), 0);
        check_idle("idle_after_cmd");
        chk(mem_diffs() == 0, "ram_contents", mem_diffs(), 0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int c;

        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_idle("reset_idle");
        end

        // Plain non-overlapping copy
        load_ram(0);
        run_cmd(0, 8, 4, 1'b0);
        for (int i = 0; i < 4; i++) chk(ram_mem[8 + i] == 32'(100 + i), "basic_copy", ram_mem[8 + i], 100 + i);

        // Forward overlap
        load_ram(1);
        run_cmd(2, 4, 5, 1'b0);
        for (int i = 0; i < 5; i++) chk(ram_mem[4 + i] == 32'(2 + i), "overlap_copy", ram_mem[4 + i], 2 + i);
        chk(ram_mem[2] == 32'sd2 && ram_mem[3] == 32'sd3, "overlap_src_keep", ram_mem[2] + ram_mem[3], 5);

        // Wrap-around overlap
        load_ram(2);
        old_mem = ram_mem;
        run_cmd(14, 1, 4, 1'b0);
        chk(ram_mem[1] == old_mem[14], "wrap_w1", ram_mem[1], old_mem[14]);
        chk(ram_mem[2] == old_mem[15], "wrap_w2", ram_mem[2], old_mem[15]);
        chk(ram_mem[3] == old_mem[0],  "wrap_w3", ram_mem[3], old_mem[0]);
        chk(ram_mem[4] == old_mem[1],  "wrap_w4", ram_mem[4], old_mem[1]);

        // Zero length, with and without start held
        run_cmd(5, 9, 0, 1'b0);
        run_cmd(3, 7, 0, 1'b1);

        // Start held during busy and FIN must be ignored
        run_cmd(3, 6, 5, 1'b1);

        // Full-RAM copy, and src == dst
        load_ram(2);
        run_cmd(0, 5, 16, 1'b0);
        run_cmd(3, 3, 4, 1'b0);

        // Reset during the third WR of a len=6 copy
        load_ram(0);
        @(negedge clk);
        c     = cyc;
        src   = DD'(0);
        dst   = DD'(8);
        len   = (DD+1)'(6);
        start = 1'b1;
        model_cmd(c, 0, 8, 6, 2);
        push(0, c + 5, 2, 0);
        @(negedge clk);
        start = 1'b0;
        while (cyc < c + 5) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_idle("reset_abort");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk(exp_q.size() == 0, "abort_events", exp_q.size(), 0);
        exp_q.delete();
        chk(mem_diffs() == 0, "abort_ram", mem_diffs(), 0);
        chk(ram_mem[8] == 32'sd100 && ram_mem[9] == 32'sd101, "abort_written", ram_mem[9], 101);
        chk(ram_mem[10] == 32'sd110, "abort_not_written", ram_mem[10], 110);
        run_cmd(0, 8, 6, 1'b0);

        // Randomized commands
        for (int t = 0; t < 14; t++) begin
            if ($urandom_range(0, 2) == 0) load_ram(2);
            run_cmd(int'($urandom_range(0, N - 1)), int'($urandom_range(0, N - 1)),
                    int'($urandom_range(0, N)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_copy_master.md
# mem_copy_master

Initiator-side engine for the single-port synchronous RAM interface used in the placement simulation memories. It accepts a block-copy command (source, destination, length), drives the RAM's read/write/addr/dataWrite port, consumes dataRead, and signals completion. It replaces hand-written testbench stimulus as the standard way to move data between RAM regions and is overlap-safe.

## Interface
- data_depth, 4, RAM address bits; RAM holds 2**data_depth words; all address arithmetic is modulo 2**data_depth
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  command strobe; sampled only in IDLE
- src  in  data_depth  first source word address
- dst  in  data_depth  first destination word address
- len  in  data_depth+1  word count, 0..2**data_depth
- busy  out  1  high from the cycle after an accepted start through the last write cycle
- done  out  1  one-cycle completion pulse
- read  out  1  RAM read strobe
- write  out  1  RAM write strobe
- addr  out  32 signed  RAM word address, zero-extended from data_depth bits
- dataWrite  out  32 signed  RAM write data
- dataRead  in  32 signed  RAM read data, valid the cycle after read is asserted

## Operation
- States: IDLE, RD, WR, FIN.
- IDLE: read=write=0, addr=0, dataWrite=0. On start: latch src, dst, len, and direction; go to RD if len≠0, otherwise go to FIN.
- Direction: descending when dst≠src and ((dst−src) mod 2**data_depth) < len; otherwise ascending.
  - Ascending cursors start at src and dst and increment.
  - Descending cursors start at src+len−1 and dst+len−1 and decrement.
  - All cursors wrap modulo 2**data_depth.
- RD: read=1, addr=src cursor, write=0. Next state is WR.
- WR: write=1, addr=dst cursor, dataWrite=dataRead (combinational from the RAM output register), read=0.
  - Advance both cursors and decrement the remaining count.
  - Next state is RD if remaining>1, else FIN.
- FIN: done=1 and busy=0 for exactly one cycle, then IDLE.
- read and write are never asserted in the same cycle.
- start outside IDLE is ignored. This includes the FIN cycle.
- src==dst is executed normally, as a read-then-rewrite of each word.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE; busy, done, read, write = 0; addr and dataWrite = 0; cursors and count = 0.
- Reset asserted mid-copy aborts immediately with no further RAM strobes. The RAM contents are left partially copied. No done pulse is produced.
- Start accepted at edge T:
  - busy=1 from T+1.
  - First RD at T+1, first WR at T+2.
  - Word k (k=0..len−1) is read at T+1+2k and written at T+2+2k.
  - done pulses at T+1+2·len with busy=0.
  - IDLE resumes at T+2+2·len, which is the earliest cycle a new start is accepted.
- len=0: no strobes; done pulses at T+1.
- len=2**data_depth: the whole RAM is copied; the count register is data_depth+1 bits wide.
- The RAM updates memory at the write edge. A read in the following RD cycle therefore sees the newly written data. This ordering is what makes the descending-order choice correct for overlapping copies.

## Structure
- Package mem_copy_pkg holds:
  - the state enum (IDLE, RD, WR, FIN)
  - the direction constants (ASC, DESC)
  - the overlap-test function
- One sub-module, mem_copy_addr_gen, holds:
  - the src/dst cursors and the remaining count
  - load, step, and direction control
  - the last-word flag
- The top level holds the FSM and the RAM-port muxing.
- The bench instantiates the existing RAM model with a matching data_depth.

## Test plan
- Reset release, then idle for 5 cycles: all outputs 0, no strobes.
- RAM[i]=i+100. Command src=0, dst=8, len=4, start at T: RAM[8..11]=100..103; read at T+1,3,5,7; write at T+2,4,6,8; done at T+9.
- Overlap forward, RAM[i]=i. Command src=2, dst=4, len=5: descending order; RAM[4..8]=2..6; RAM[2..3] unchanged.
- Wrap: src=14, dst=1, len=4 with data_depth=4: RAM[1..4] equals the old RAM[14], RAM[15], RAM[0], RAM[1]. Because these regions overlap, the order is descending and the old values are preserved.
- len=0 pulses done at T+1 with no strobes. A start asserted during busy is ignored: exactly one done per accepted command.
- Reset is asserted during the third WR of a len=6 copy:
  - outputs go to 0 asynchronously;
  - only two words have been written;
  - no done pulse is produced;
  - a new command after release completes correctly.
